goertzel_detector: RTL and testbench

GOERTZEL_DETECTOR -- requirements
Module: goertzel_detector

---
 rtl/goertzel_detector.sv | 156 +++++++++++++++
 tb/tb_goertzel_detector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_detector.sv
// Goertzel single-tone energy detector.
// Q2.29 coefficient/samples, Q10.29 recursion state, Q34.29 power.
module goertzel_detector (
  input  logic        Fg_CLK,
  input  logic        RESET,
  input  logic        Start,
  input  logic [31:0] coef,
  input  logic [15:0] len,
  input  logic        sample_valid,
  input  logic [31:0] sample,
  output logic        Busy,
  output logic        Done,
  output logic [63:0] power
);

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    POW1,
    POW2,
    DONE
  } state_t;

  state_t state, state_n;

  logic        [31:0] coef_r;
  logic        [15:0] n_r;
  logic        [15:0] cnt;
  logic signed [39:0] s1;
  logic signed [39:0] s2;
  logic        [39:0] s0;

  logic signed [71:0] cx;
  logic signed [71:0] sx;
  logic signed [71:0] prod;
  logic signed [71:0] prod_sh;
  logic signed [71:0] cs1;

  logic signed [79:0] s1x;
  logic signed [79:0] s2x;
  logic signed [79:0] sq1;
  logic signed [79:0] sq2;

  logic signed [95:0] a96;
  logic signed [95:0] b96;
  logic signed [95:0] c96;
  logic signed [95:0] d96;
  logic signed [95:0] p_full;
  logic signed [95:0] p_sh;

  logic [63:0] pow_c;
  logic [63:0] pow_nx;

  logic start_go;
  logic accept;
  logic last;

  always_comb begin
    start_go = Start & (len != 16'd0);
    accept   = (state == ACCUM) & sample_valid & ~Start;
    last     = (cnt == n_r - 16'd1);
  end

  // one shared coef*s1 multiplier serves the recursion and POW1
  always_comb begin
    cx      = {{40{coef_r[31]}}, coef_r};
    sx      = {{32{s1[39]}}, s1};
    prod    = cx * sx;
    prod_sh = prod >>> 29;
    s0      = {{8{sample[31]}}, sample}
            + prod_sh[39:0] - s2;
    s1x     = {{40{s1[39]}}, s1};
    s2x     = {{40{s2[39]}}, s2};
  end

  always_comb begin
    a96    = {{16{sq1[79]}}, sq1};
    b96    = {{16{sq2[79]}}, sq2};
    c96    = {{24{cs1[71]}}, cs1};
    d96    = {{56{s2[39]}}, s2};
    p_full = a96 + b96 - c96 * d96;
    p_sh   = p_full >>> 29;
    pow_c  = p_sh[63:0];
    if (p_sh[95])
      pow_c = '0;
    else if (|p_sh[95:64])
      pow_c = '1;
  end

  always_comb begin
    state_n = state;
    if (start_go)
      state_n = ACCUM;
    else if (Start)
      state_n = IDLE;
    else begin
      unique case (state)
        IDLE:    state_n = IDLE;
        ACCUM:   if (accept && last) state_n = POW1;
        POW1:    state_n = POW2;
        POW2:    state_n = DONE;
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      coef_r <= '0;
      n_r    <= '0;
      cnt    <= '0;
      s1     <= '0;
      s2     <= '0;
      sq1    <= '0;
      sq2    <= '0;
      cs1    <= '0;
      pow_nx <= '0;
      power  <= '0;
      Done   <= 1'b0;
    end else begin
      if (start_go) begin
        coef_r <= coef;
        n_r    <= len;
        cnt    <= '0;
        s1     <= '0;
        s2     <= '0;
      end else if (accept) begin
        s2  <= s1;
        s1  <= s0;
        cnt <= cnt + 16'd1;
      end
      if (state == POW1) begin
        sq1 <= s1x * s1x;
        sq2 <= s2x * s2x;
        cs1 <= prod_sh;
      end
      if (state == POW2)
        pow_nx <= pow_c;
      // a Start landing in DONE aborts: no pulse, power kept
      Done <= (state == DONE) & ~Start;
      if (state == DONE && !Start)
        power <= pow_nx;
    end
  end

  assign Busy = (state != IDLE) | Done;

endmodule

// File: tb/tb_goertzel_detector.sv
// Directed and randomized checks of goertzel_detector
// against a 96-bit full-precision reference model.
module tb_goertzel_detector;

  logic        Fg_CLK = 1'b0;
  logic        RESET;
  logic        Start;
  logic [31:0] coef;
  logic [15:0] len;
  logic        sample_valid;
  logic [31:0] sample;
  logic        Busy;
  logic        Done;
  logic [63:0] power;

  int n_vec    = 0;
  int n_err    = 0;
  int done_cnt = 0;
  int d0;

  logic [31:0] smp_q[$];

  goertzel_detector dut (
    .Fg_CLK      (Fg_CLK),
    .RESET       (RESET),
    .Start       (Start),
    .coef        (coef),
    .len         (len),
    .sample_valid(sample_valid),
    .sample      (sample),
    .Busy        (Busy),
    .Done        (Done),
    .power       (power)
  );

  always #5 Fg_CLK = ~Fg_CLK;

  always @(negedge Fg_CLK)
    if (Done) done_cnt++;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge Fg_CLK);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [31:0] c);
    logic signed [95:0] cc, a, b, x, t, p;
    logic signed [31:0] c32, x32;
    logic signed [39:0] w;
    c32 = c;
    cc  = c32;
    a   = '0;
    b   = '0;
    foreach (smp_q[i]) begin
      x32 = smp_q[i];
      x   = x32;
      t   = (cc * a) >>> 29;
      w   = 40'(x + t - b);
      b   = a;
      a   = w;
    end
    t = (cc * a) >>> 29;
    p = (a * a + b * b - t * b) >>> 29;
    if (p < 0) return 64'd0;
    if (p > $signed(96'h0_FFFF_FFFF_FFFF_FFFF))
      return '1;
    return p[63:0];
  endfunction

  task automatic run_block(input logic [31:0] c,
                           input int gap_pct,
                           input logic [63:0] exp,
                           input string tag);
    int b0;
    int lat;
    b0 = done_cnt;
    Start        = 1'b1;
    coef         = c;
    len          = 16'(smp_q.size());
    sample_valid = 1'b1;
    sample       = $urandom;
    tick;
    Start = 1'b0;
    chk({tag, ".busy"}, 64'(Busy), 64'd1);
    foreach (smp_q[i]) begin
      for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++) begin
        sample_valid = 1'b0;
        sample       = $urandom;
        tick;
      end
      sample_valid = 1'b1;
      sample       = smp_q[i];
      tick;
    end
    sample_valid = 1'b1;
    sample       = $urandom;
    lat          = 0;
    while (!Done && lat < 10) begin
      tick;
      lat++;
    end
    sample_valid = 1'b0;
    chk({tag, ".lat"}, 64'(lat), 64'd3);
    chk({tag, ".pow"}, power, exp);
    tick;
    chk({tag, ".one"}, 64'(done_cnt - b0), 64'd1);
    chk({tag, ".end"}, {62'd0, Busy, Done}, 64'd0);
  endtask

  initial begin
    RESET        = 1'b1;
    Start        = 1'b0;
    sample_valid = 1'b0;
    coef         = '0;
    len          = '0;
    sample       = '0;
    repeat (2) tick;
    chk("rst.state", {62'd0, Busy, Done}, 64'd0);
    chk("rst.pow", power, 64'd0);
    RESET = 1'b0;
    tick;

    smp_q = '{32'h2000_0000};
    run_block(32'h4000_0000, 0, 64'h2000_0000, "dc1");

    smp_q = '{32'h2000_0000, 32'h2000_0000};
    run_block(32'h0, 100, 64'h4000_0000, "n2");

    smp_q = '{32'h2000_0000, 32'hA000_0001};
    run_block(32'h7FFF_FFFF, 0, 64'd0, "negclamp");

    smp_q = '{32'h2000_0000, 32'h0, 32'hE000_0000, 32'h0};
    run_block(32'h0, 0, 64'h8000_0000, "tone4");

    Start = 1'b1;
    len   = 16'd0;
    tick;
    Start = 1'b0;
    chk("len0.busy", 64'(Busy), 64'd0);
    chk("len0.pow", power, 64'h8000_0000);

    d0    = done_cnt;
    Start = 1'b1;
    coef  = $urandom;
    len   = 16'd8;
    tick;
    Start        = 1'b0;
    sample_valid = 1'b1;
    repeat (3) begin
      sample = $urandom;
      tick;
    end
    sample_valid = 1'b0;
    chk("abortA.hold", power, 64'h8000_0000);
    smp_q = '{32'h2000_0000};
    run_block(32'h4000_0000, 0, 64'h2000_0000, "abortB");
    chk("abort.ndone", 64'(done_cnt - d0), 64'd1);

    Start = 1'b1;
    coef  = 32'h4000_0000;
    len   = 16'd5;
    tick;
    Start        = 1'b0;
    sample_valid = 1'b1;
    sample       = 32'h2000_0000;
    repeat (2) tick;
    Start = 1'b1;
    len   = 16'd0;
    tick;
    Start = 1'b0;
    chk("abort0.busy", 64'(Busy), 64'd0);
    d0 = done_cnt;
    repeat (10) tick;
    sample_valid = 1'b0;
    chk("abort0.ndone", 64'(done_cnt - d0), 64'd0);
    chk("abort0.pow", power, 64'h2000_0000);

    Start = 1'b1;
    coef  = 32'h4000_0000;
    len   = 16'd8;
    tick;
    Start        = 1'b0;
    sample_valid = 1'b1;
    repeat (3) begin
      sample = $urandom;
      tick;
    end
    #2 RESET = 1'b1;
    #1;
    chk("arst.state", {62'd0, Busy, Done}, 64'd0);
    chk("arst.pow", power, 64'd0);
    tick;
    RESET = 1'b0;
    d0    = done_cnt;
    repeat (20) begin
      sample = $urandom;
      tick;
    end
    sample_valid = 1'b0;
    chk("arst.ndone", 64'(done_cnt - d0), 64'd0);
    chk("arst.busy", 64'(Busy), 64'd0);

    repeat (1000) begin
      logic [31:0] c;
      int          l;
      c = $urandom;
      l = $urandom_range(64, 1);
      smp_q.delete();
      for (int i = 0; i < l; i++)
        smp_q.push_back($urandom);
      run_block(c, 15, model(c), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
